// File: rtl/mux_pkg.sv
// Shared encodings and sizing helpers for the channel multiplexer and its arbiter.
package mux_pkg;

   localparam int unsigned MODE_SEL = 0;
   localparam int unsigned MODE_RR  = 1;

   localparam int unsigned NCH_MIN = 2;
   localparam int unsigned NCH_MAX = 16;

   // Channel-index width: clog2 of the channel count, never below one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: first requester at or above ptr, wrapping from NCH-1 to 0.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int unsigned NCH = 4,
   localparam int unsigned PW  = sel_width(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [PW-1:0]  idx
);

   int unsigned pos;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned i = 0; i < NCH; i++) begin
         // ptr < NCH and i < NCH, so one conditional subtract is a full modulo.
         pos = 32'(ptr) + i;
         if (pos >= NCH) begin
            pos = pos - NCH;
         end
         if (!found && req[PW'(pos)]) begin
            found            = 1'b1;
            grant[PW'(pos)]  = 1'b1;
            idx              = PW'(pos);
         end
      end
   end

endmodule

// File: rtl/rr_mux.sv
// N-channel valid/ready multiplexer into a single-entry output register,
// channel chosen by sel (MODE_SEL) or by a rotating round-robin pointer (MODE_RR).
module rr_mux
   import mux_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned NCH   = 4,
   parameter  int unsigned MODE  = MODE_SEL,
   localparam int unsigned SW    = sel_width(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [SW-1:0]        sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SW-1:0]        out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SW-1:0]    ptr_q,   ptr_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [SW-1:0]    ch_q,    ch_d;
   logic             valid_q, valid_d;

   logic             free_c;
   logic [NCH-1:0]   sel_grant_c;
   logic [NCH-1:0]   rr_grant_c;
   logic [NCH-1:0]   grant_c;
   logic [SW-1:0]    rr_idx_c;
   logic             xfer_c;
   logic [WIDTH-1:0] xfer_data_c;
   logic [SW-1:0]    xfer_ch_c;

   rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .req   (in_valid),
      .ptr   (ptr_q),
      .grant (rr_grant_c),
      .idx   (rr_idx_c)
   );

   // The output register can take a word when empty or when drained this cycle.
   assign free_c = !valid_q || out_ready;

   // Select-mode grant; an out-of-range sel grants nobody.
   always_comb begin
      sel_grant_c = '0;
      if (32'(sel) < NCH) begin
         sel_grant_c[sel] = 1'b1;
      end
   end

   assign grant_c  = (MODE == MODE_RR) ? rr_grant_c : sel_grant_c;
   assign in_ready = (rst || !free_c) ? '0 : (grant_c & in_valid);
   assign xfer_c   = |in_ready;

   // AND-OR data mux keyed by the one-hot in_ready.
   always_comb begin
      xfer_data_c = '0;
      xfer_ch_c   = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (in_ready[k]) begin
            xfer_data_c = xfer_data_c | in_data[k*WIDTH +: WIDTH];
            xfer_ch_c   = SW'(k);
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      if (xfer_c) begin
         valid_d = 1'b1;
         data_d  = xfer_data_c;
         ch_d    = xfer_ch_c;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
      if ((MODE == MODE_RR) && xfer_c) begin
         ptr_d = (32'(rr_idx_c) == NCH - 1) ? '0 : rr_idx_c + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = valid_q;

   a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));
   a_hold_stalled: assert property (@(posedge clk) disable iff (rst)
      (valid_q && !out_ready) |=> ($stable(data_q) && $stable(ch_q) && valid_q));

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux: select mode (4 and 3 channels) and round-robin mode.
module tb_rr_mux;
   import mux_pkg::*;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [1:0]   ch;
      logic [W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [4*W-1:0] d4;
   logic [3:0]     v_s, rdy_s, v_r, rdy_r;
   logic [1:0]     sel_s, sel_r, oc_s, oc_r;
   logic [W-1:0]   od_s, od_r;
   logic           ov_s, ov_r, ordy_s, ordy_r;

   logic [3*W-1:0] d3;
   logic [2:0]     v_3, rdy_3;
   logic [1:0]     sel_3, oc_3;
   logic [W-1:0]   od_3;
   logic           ov_3, ordy_3;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];

   rr_mux #(.WIDTH(W), .NCH(4), .MODE(MODE_SEL)) u_sel (
      .clk(clk), .rst(rst), .in_data(d4), .in_valid(v_s), .in_ready(rdy_s), .sel(sel_s),
      .out_data(od_s), .out_ch(oc_s), .out_valid(ov_s), .out_ready(ordy_s));

   rr_mux #(.WIDTH(W), .NCH(4), .MODE(MODE_RR)) u_rr (
      .clk(clk), .rst(rst), .in_data(d4), .in_valid(v_r), .in_ready(rdy_r), .sel(sel_r),
      .out_data(od_r), .out_ch(oc_r), .out_valid(ov_r), .out_ready(ordy_r));

   rr_mux #(.WIDTH(W), .NCH(3), .MODE(MODE_SEL)) u_sel3 (
      .clk(clk), .rst(rst), .in_data(d3), .in_valid(v_3), .in_ready(rdy_3), .sel(sel_3),
      .out_data(od_3), .out_ch(oc_3), .out_valid(ov_3), .out_ready(ordy_3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t word(input int unsigned k);
      exp_t e;
      e.ch   = 2'(k);
      e.data = W'(d4 >> (k * W));
      return e;
   endfunction

   // Reference round-robin choice: scan channels p, p+1, ... modulo 4.
   function automatic logic [3:0] rr_pick(input logic [3:0] req, input int unsigned p);
      for (int unsigned i = 0; i < 4; i++) begin
         if (req[2'((p + i) % 4)]) return 4'(1 << ((p + i) % 4));
      end
      return 4'b0000;
   endfunction

   function automatic int unsigned idx_of(input logic [3:0] g);
      for (int unsigned i = 0; i < 4; i++) begin
         if (g[2'(i)]) return i;
      end
      return 0;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      d4 = 32'h4433_2211; d3 = 24'h66_5544;
      v_s = '1; v_r = '1; v_3 = '1;
      sel_s = 2'd0; sel_r = 2'd0; sel_3 = 2'd0;
      ordy_s = 1'b1; ordy_r = 1'b1; ordy_3 = 1'b1;
      #1;
      n_cmp++; if (rdy_s !== 4'b0000) begin n_bad++; $display("FAIL rst_rdy_sel: got %b want 0000", rdy_s); end
      n_cmp++; if (rdy_r !== 4'b0000) begin n_bad++; $display("FAIL rst_rdy_rr: got %b want 0000", rdy_r); end
      tick();
      tick();
      n_cmp++; if (rdy_3 !== 3'b000) begin n_bad++; $display("FAIL rst_rdy_sel3: got %b want 000", rdy_3); end
      n_cmp++; if (ov_s !== 1'b0 || od_s !== 8'h00 || oc_s !== 2'd0) begin n_bad++; $display("FAIL rst_out_sel: got v=%b d=%h c=%0d want 0/00/0", ov_s, od_s, oc_s); end
      n_cmp++; if (ov_r !== 1'b0 || od_r !== 8'h00 || oc_r !== 2'd0) begin n_bad++; $display("FAIL rst_out_rr: got v=%b d=%h c=%0d want 0/00/0", ov_r, od_r, oc_r); end
      n_cmp++; if (ov_3 !== 1'b0) begin n_bad++; $display("FAIL rst_out_sel3: got v=%b want 0", ov_3); end
      rst = 1'b0;
      v_s = '0; v_r = '0; v_3 = '0;
   endtask

   task automatic test_sel_basic();
      exp_t e;
      sel_s = 2'd2; v_s = 4'b1111; d4 = 32'h3CA5_5A0F; ordy_s = 1'b1;
      #1;
      n_cmp++; if (rdy_s !== 4'b0100) begin n_bad++; $display("FAIL sel2_rdy: got %b want 0100", rdy_s); end
      q.push_back(word(2));
      tick();
      e = q.pop_front();
      n_cmp++; if (ov_s !== 1'b1 || od_s !== e.data || oc_s !== e.ch || od_s !== 8'hA5) begin n_bad++; $display("FAIL sel2_out: got v=%b d=%h c=%0d want 1/%h/%0d", ov_s, od_s, oc_s, e.data, e.ch); end
      for (int unsigned k = 0; k < 4; k++) begin
         sel_s = 2'(k); d4 = $urandom; v_s = 4'b1111;
         #1;
         n_cmp++; if (rdy_s !== 4'(1 << k)) begin n_bad++; $display("FAIL sel_sweep_rdy: got %b want %b", rdy_s, 4'(1 << k)); end
         q.push_back(word(k));
         tick();
         e = q.pop_front();
         n_cmp++; if (ov_s !== 1'b1 || od_s !== e.data || oc_s !== e.ch) begin n_bad++; $display("FAIL sel_sweep_out: got v=%b d=%h c=%0d want 1/%h/%0d", ov_s, od_s, oc_s, e.data, e.ch); end
      end
      // sel names an idle channel while others are valid
      sel_s = 2'd1; v_s = 4'b1101;
      #1;
      n_cmp++; if (rdy_s !== 4'b0000) begin n_bad++; $display("FAIL sel_idle_rdy: got %b want 0000", rdy_s); end
      tick();
      n_cmp++; if (ov_s !== 1'b0) begin n_bad++; $display("FAIL sel_drain: got v=%b want 0", ov_s); end
      v_s = 4'b0000;
      #1;
      n_cmp++; if (rdy_s !== 4'b0000) begin n_bad++; $display("FAIL sel_novalid_rdy: got %b want 0000", rdy_s); end
      tick();
   endtask

   task automatic test_rr_rotation();
      exp_t e;
      v_r = 4'b1111; ordy_r = 1'b1;
      for (int unsigned c = 0; c < 5; c++) begin
         d4 = $urandom;
         #1;
         n_cmp++; if (rdy_r !== 4'(1 << (c % 4))) begin n_bad++; $display("FAIL rot_rdy: got %b want %b", rdy_r, 4'(1 << (c % 4))); end
         q.push_back(word(c % 4));
         tick();
         e = q.pop_front();
         n_cmp++; if (ov_r !== 1'b1 || oc_r !== e.ch || od_r !== e.data) begin n_bad++; $display("FAIL rot_out: got v=%b c=%0d d=%h want 1/%0d/%h", ov_r, oc_r, od_r, e.ch, e.data); end
      end
   endtask

   task automatic test_rr_wrap();
      exp_t e;
      v_r = 4'b0100;
      #1;
      n_cmp++; if (rdy_r !== 4'b0100) begin n_bad++; $display("FAIL wrap_pre_rdy: got %b want 0100", rdy_r); end
      q.push_back(word(2));
      tick();
      e = q.pop_front();
      n_cmp++; if (oc_r !== e.ch || od_r !== e.data) begin n_bad++; $display("FAIL wrap_pre_out: got c=%0d d=%h want %0d/%h", oc_r, od_r, e.ch, e.data); end
      v_r = 4'b0010;
      #1;
      n_cmp++; if (rdy_r !== 4'b0010) begin n_bad++; $display("FAIL wrap_rdy: got %b want 0010", rdy_r); end
      q.push_back(word(1));
      tick();
      e = q.pop_front();
      n_cmp++; if (ov_r !== 1'b1 || oc_r !== e.ch || od_r !== e.data) begin n_bad++; $display("FAIL wrap_out: got v=%b c=%0d d=%h want 1/%0d/%h", ov_r, oc_r, od_r, e.ch, e.data); end
      v_r = 4'b1111;
      #1;
      n_cmp++; if (rdy_r !== 4'b0100) begin n_bad++; $display("FAIL wrap_ptr2: got %b want 0100", rdy_r); end
      q.push_back(word(2));
      tick();
      e = q.pop_front();
      n_cmp++; if (oc_r !== e.ch || od_r !== e.data) begin n_bad++; $display("FAIL wrap_ptr2_out: got c=%0d d=%h want %0d/%h", oc_r, od_r, e.ch, e.data); end
      v_r = 4'b0000;
      #1;
      n_cmp++; if (rdy_r !== 4'b0000) begin n_bad++; $display("FAIL rr_novalid_rdy: got %b want 0000", rdy_r); end
      tick();
      n_cmp++; if (ov_r !== 1'b0) begin n_bad++; $display("FAIL rr_drain: got v=%b want 0", ov_r); end
   endtask

   task automatic test_backpressure();
      exp_t held;
      v_r = 4'b1111; ordy_r = 1'b0; d4 = $urandom;
      #1;
      n_cmp++; if (rdy_r !== 4'b1000) begin n_bad++; $display("FAIL bp_load_rdy: got %b want 1000", rdy_r); end
      q.push_back(word(3));
      tick();
      held = q.pop_front();
      for (int unsigned n = 0; n < 3; n++) begin
         d4 = $urandom;
         #1;
         n_cmp++; if (rdy_r !== 4'b0000) begin n_bad++; $display("FAIL bp_stall_rdy: got %b want 0000", rdy_r); end
         tick();
         n_cmp++; if (ov_r !== 1'b1 || od_r !== held.data || oc_r !== held.ch) begin n_bad++; $display("FAIL bp_hold: got v=%b d=%h c=%0d want 1/%h/%0d", ov_r, od_r, oc_r, held.data, held.ch); end
      end
      ordy_r = 1'b1;
      #1;
      n_cmp++; if (rdy_r !== 4'b0001) begin n_bad++; $display("FAIL bp_release_rdy: got %b want 0001", rdy_r); end
      q.push_back(word(0));
      tick();
      held = q.pop_front();
      n_cmp++; if (ov_r !== 1'b1 || od_r !== held.data || oc_r !== held.ch) begin n_bad++; $display("FAIL bp_release_out: got v=%b d=%h c=%0d want 1/%h/%0d", ov_r, od_r, oc_r, held.data, held.ch); end
   endtask

   task automatic test_sel_out_of_range();
      logic [W-1:0] want;
      sel_3 = 2'd3; v_3 = 3'b111; ordy_3 = 1'b1; d3 = 24'h77_C3_19;
      for (int unsigned n = 0; n < 3; n++) begin
         #1;
         n_cmp++; if (rdy_3 !== 3'b000) begin n_bad++; $display("FAIL sel3_oor_rdy: got %b want 000", rdy_3); end
         tick();
         n_cmp++; if (ov_3 !== 1'b0) begin n_bad++; $display("FAIL sel3_oor_valid: got v=%b want 0", ov_3); end
      end
      sel_3 = 2'd1;
      want  = d3[1*W +: W];
      #1;
      n_cmp++; if (rdy_3 !== 3'b010) begin n_bad++; $display("FAIL sel3_ch1_rdy: got %b want 010", rdy_3); end
      tick();
      n_cmp++; if (ov_3 !== 1'b1 || oc_3 !== 2'd1 || od_3 !== want) begin n_bad++; $display("FAIL sel3_ch1_out: got v=%b c=%0d d=%h want 1/1/%h", ov_3, oc_3, od_3, want); end
      v_3 = 3'b000;
   endtask

   task automatic test_reset_midflight();
      exp_t e;
      v_r = 4'b0010; ordy_r = 1'b1; d4 = $urandom;
      #1;
      n_cmp++; if (rdy_r !== 4'b0010) begin n_bad++; $display("FAIL mid_rdy: got %b want 0010", rdy_r); end
      q.push_back(word(1));
      tick();
      e = q.pop_front();
      n_cmp++; if (ov_r !== 1'b1 || oc_r !== e.ch) begin n_bad++; $display("FAIL mid_out: got v=%b c=%0d want 1/%0d", ov_r, oc_r, e.ch); end
      rst = 1'b1; v_r = 4'b1111; ordy_r = 1'b1;
      #1;
      n_cmp++; if (rdy_r !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_rdy: got %b want 0000", rdy_r); end
      tick();
      rst = 1'b0;
      n_cmp++; if (ov_r !== 1'b0 || od_r !== 8'h00 || oc_r !== 2'd0) begin n_bad++; $display("FAIL mid_rst_out: got v=%b d=%h c=%0d want 0/00/0", ov_r, od_r, oc_r); end
      #1;
      n_cmp++; if (rdy_r !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0001", rdy_r); end
      q.push_back(word(0));
      tick();
      e = q.pop_front();
      n_cmp++; if (ov_r !== 1'b1 || oc_r !== e.ch || od_r !== e.data) begin n_bad++; $display("FAIL mid_first_out: got v=%b c=%0d d=%h want 1/%0d/%h", ov_r, oc_r, od_r, e.ch, e.data); end
   endtask

   task automatic test_random_rr();
      int unsigned m_ptr;
      logic        m_ov;
      logic        free;
      logic [3:0]  exp_rdy;
      int unsigned k;
      exp_t        held;
      rst = 1'b1; v_r = '0;
      tick();
      rst   = 1'b0;
      m_ptr = 0;
      m_ov  = 1'b0;
      held  = '0;
      for (int n = 0; n < 300; n++) begin
         v_r    = 4'($urandom);
         ordy_r = ($urandom_range(0, 3) != 0);
         d4     = $urandom;
         #1;
         free    = !m_ov || ordy_r;
         exp_rdy = free ? rr_pick(v_r, m_ptr) : 4'b0000;
         n_cmp++; if (rdy_r !== exp_rdy) begin n_bad++; $display("FAIL rand_rdy[%0d]: got %b want %b", n, rdy_r, exp_rdy); end
         if (|exp_rdy) begin
            k     = idx_of(exp_rdy);
            q.push_back(word(k));
            m_ptr = (k + 1) % 4;
         end
         tick();
         if (|exp_rdy) begin
            held = q.pop_front();
            m_ov = 1'b1;
         end else if (ordy_r) begin
            m_ov = 1'b0;
         end
         n_cmp++; if (ov_r !== m_ov) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b want %b", n, ov_r, m_ov); end
         if (m_ov) begin
            n_cmp++; if (od_r !== held.data || oc_r !== held.ch) begin n_bad++; $display("FAIL rand_out[%0d]: got d=%h c=%0d want %h/%0d", n, od_r, oc_r, held.data, held.ch); end
         end
      end
      v_r = '0;
   endtask

   initial begin
      test_reset();
      test_sel_basic();
      test_rr_rotation();
      test_rr_wrap();
      test_backpressure();
      test_sel_out_of_range();
      test_reset_midflight();
      test_random_rr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter NCH, default 4, number of input channels, legal range 2..16.
REQ-003 SHALL have parameter MODE, default 0: 0 = select by sel port, 1 = round-robin.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_data, input, NCH*WIDTH, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, NCH, channel k offers data.
REQ-008 SHALL have port in_ready, output, NCH, channel k transfer accepted this cycle.
REQ-009 SHALL have port sel, input, SW = max(1,clog2(NCH)), channel choice in MODE 0.
REQ-010 SHALL have port out_data, output, WIDTH, registered selected data.
REQ-011 SHALL have port out_ch, output, SW, source channel of out_data.
REQ-012 SHALL have port out_valid, output, 1, out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts when high with out_valid.

Function
REQ-014 SHALL hold a single-entry output register; free when out_valid=0 or out_ready=1 in the same cycle.
REQ-015 SHALL assert at most one in_ready bit per cycle, only for the granted channel, and only when the output register is free.
REQ-016 SHALL transfer on input k when in_valid[k] and in_ready[k] are both high; out_data/out_ch/out_valid update on the next edge (latency 1 cycle).
REQ-017 SHALL, in MODE 0, grant only channel sel; sel >= NCH grants none; in_ready is combinational from sel.
REQ-018 SHALL, in MODE 1, grant the first valid channel at or after pointer ptr, searching upward with wrap from NCH-1 to 0.
REQ-019 SHALL, in MODE 1, set ptr to (granted+1) mod NCH after each accepted transfer; ptr SHALL stay unchanged when no transfer occurs.
REQ-020 SHALL clear out_valid on an edge where out_ready=1 and no new transfer occurs.
REQ-021 SHALL, when consume and new transfer coincide, load the new word with out_valid held at 1, giving full throughput of one word per cycle.
REQ-022 SHALL hold out_data and out_ch stable while out_valid=1 and out_ready=0.
REQ-023 SHALL assert no in_ready bit when no in_valid bit is high.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, set out_valid=0, out_data=0, out_ch=0 and ptr=0.
REQ-025 SHALL drop an in-flight word on reset; in_ready SHALL be all zero while rst=1.

Structure
REQ-026 SHALL take mode encodings (MODE_SEL=0, MODE_RR=1) and the SW width function from shared package mux_pkg.
REQ-027 SHALL implement the round-robin grant search in sub-module rr_arbiter (inputs req, ptr; output one-hot grant and index).

Verification
REQ-028 SHALL cover MODE 0, NCH=4, WIDTH=8, sel=2, in_valid=4'b1111, data2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2.
REQ-029 SHALL cover MODE 1, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-030 SHALL cover MODE 1, ptr=3, only channel 1 valid -> grant 1 (wrap), ptr becomes 2.
REQ-031 SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data unchanged; out_ready=1 with in_valid high -> new word loaded, out_valid stays 1.
REQ-032 SHALL cover MODE 0, sel=3 with NCH=3 -> in_ready=0, out_valid stays 0.
REQ-033 SHALL cover rst asserted with out_valid=1 and ptr=2 -> next cycle out_valid=0, out_data=0, ptr=0, first grant goes to channel 0.
